// File: rtl/fp32_mul_pkg.sv
// Shared constants and types for the fp32 multiplier output stage.
// Holds binary32 field constants, flag bit positions, and the S1 register bundle.
package fp32_mul_pkg;

    localparam int unsigned EXP_W   = 10;   // signed biased exponent from the multiply stage
    localparam int unsigned MANT_W  = 24;   // significand with hidden bit
    localparam int unsigned PROD_W  = 48;   // raw 24x24 product
    localparam int unsigned FLAG_W  = 4;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    // out_flags = {NV, OF, UF, NX}
    localparam int unsigned FLG_NV = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 0;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } op_class_t;

    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   e;
        logic [MANT_W-1:0]  m;
        logic [FLAG_W-1:0]  flags;
        op_class_t          cls;
    } s1_reg_t;

endpackage

// File: rtl/fp32_mul_round_pack_if.sv
// Upstream/downstream handshake bundle for fp32_mul_round_pack.
// slave: the round/pack stage; master: the producer/consumer side driving it.
interface fp32_mul_round_pack_if;
    import fp32_mul_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [EXP_W-1:0]    in_exp;
    logic [PROD_W-1:0]   in_mant;
    logic                in_nan;
    logic                in_inf;
    logic                in_zero;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_f;
    logic [FLAG_W-1:0]   out_flags;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
        output in_ready, out_valid, out_f, out_flags
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
        input  in_ready, out_valid, out_f, out_flags
    );

endinterface

// File: rtl/fp32_rne_round.sv
// Combinational normalise + round-to-nearest-even of the raw product.
// Ports: mant (48b product, leading one at bit 47 or 46), exp_in (signed biased exp),
//        m (rounded 24b significand incl. hidden bit), e (adjusted exp), inexact.
module fp32_rne_round
    import fp32_mul_pkg::*;
(
    input  logic [PROD_W-1:0] mant,
    input  logic [EXP_W-1:0]  exp_in,
    output logic [MANT_W-1:0] m,
    output logic [EXP_W-1:0]  e,
    output logic              inexact
);

    logic [MANT_W-1:0] m_n;
    logic [EXP_W-1:0]  e_n;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   sum;

    // Select the 24 significant bits, then round half to even.
    always_comb begin
        m_n     = mant[46:23];
        e_n     = exp_in;
        guard   = mant[22];
        sticky  = |mant[21:0];
        if (mant[PROD_W-1]) begin
            m_n    = mant[47:24];
            e_n    = exp_in + EXP_W'(1);
            guard  = mant[23];
            sticky = |mant[22:0];
        end
        round_up = guard & (sticky | m_n[0]);
        sum      = {1'b0, m_n} + (MANT_W+1)'(round_up);
        m        = sum[MANT_W-1:0];
        e        = e_n;
        // All-ones significand rounded up: renormalise to 1.0 x 2^(e+1).
        if (sum[MANT_W]) begin
            m = {1'b1, {(MANT_W-1){1'b0}}};
            e = e_n + EXP_W'(1);
        end
        inexact = guard | sticky;
    end

endmodule

// File: rtl/fp32_mul_round_pack.sv
// Output stage of the fp32 multiplier: normalise/round (S1), range check + pack (S2).
// Ports: clk, rst (async, active high), bus (fp32_mul_round_pack_if.slave:
//        in_* product + valid/ready, out_f/out_flags + valid/ready).
// Optional FP32_MUL_STICKY_FLAGS_EN adds flags_sticky (out, 4) and flags_clr (in, 1).
module fp32_mul_round_pack
    import fp32_mul_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    fp32_mul_round_pack_if.slave      bus
`ifdef FP32_MUL_STICKY_FLAGS_EN
    ,
    output logic [FLAG_W-1:0]         flags_sticky,
    input  logic                      flags_clr
`endif
);

    localparam logic signed [EXP_W-1:0] E_MAX_S  = EXP_W'(EXP_MAX);
    localparam logic signed [EXP_W-1:0] E_ZERO_S = '0;

    logic [MANT_W-1:0] rnd_m;
    logic [EXP_W-1:0]  rnd_e;
    logic              rnd_nx;
    s1_reg_t           s1_d;
    s1_reg_t           s1_q;
    logic              s1_valid;
    logic              out_valid_q;
    logic [31:0]       out_f_q;
    logic [FLAG_W-1:0] out_flags_q;
    logic              s2_ready;
    logic              in_ready;
    logic [31:0]       pack_f;
    logic [FLAG_W-1:0] pack_flags;
    logic signed [EXP_W-1:0] e_s;
    logic              unused_hidden;

    fp32_rne_round u_round (
        .mant    (bus.in_mant),
        .exp_in  (bus.in_exp),
        .m       (rnd_m),
        .e       (rnd_e),
        .inexact (rnd_nx)
    );

    // S1 holds NX from rounding only; S2 decides the final flag set.
    always_comb begin
        s1_d              = '0;
        s1_d.sign         = bus.in_sign;
        s1_d.e            = rnd_e;
        s1_d.m            = rnd_m;
        s1_d.flags[FLG_NX] = rnd_nx;
        s1_d.cls.nan      = bus.in_nan;
        s1_d.cls.inf      = bus.in_inf;
        s1_d.cls.zero     = bus.in_zero;
    end

    // S2 is free when empty or draining; S1 may take new data when it can empty into S2.
    assign s2_ready     = !out_valid_q || bus.out_ready;
    assign in_ready     = !s1_valid || s2_ready;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Specials take priority over the arithmetic result, then overflow/underflow.
    assign e_s           = $signed(s1_q.e);
    assign unused_hidden = s1_q.m[MANT_W-1];

    always_comb begin
        pack_f     = {s1_q.sign, s1_q.e[7:0], s1_q.m[22:0]};
        pack_flags = s1_q.flags;
        if (s1_q.cls.nan || (s1_q.cls.inf && s1_q.cls.zero)) begin
            pack_f             = QNAN;
            pack_flags         = '0;
            pack_flags[FLG_NV] = s1_q.cls.inf && s1_q.cls.zero;
        end else if (s1_q.cls.inf) begin
            pack_f     = {s1_q.sign, INF_MAG};
            pack_flags = '0;
        end else if (s1_q.cls.zero) begin
            pack_f     = {s1_q.sign, 31'h0};
            pack_flags = '0;
        end else if (e_s >= E_MAX_S) begin
            pack_f             = {s1_q.sign, INF_MAG};
            pack_flags         = '0;
            pack_flags[FLG_OF] = 1'b1;
            pack_flags[FLG_NX] = 1'b1;
        end else if (e_s <= E_ZERO_S) begin
            pack_f             = {s1_q.sign, 31'h0};
            pack_flags         = '0;
            pack_flags[FLG_UF] = 1'b1;
            pack_flags[FLG_NX] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_flags_q <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_f_q     <= pack_f;
                out_flags_q <= pack_flags;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_f     = out_f_q;
    assign bus.out_flags = out_flags_q;

`ifdef FP32_MUL_STICKY_FLAGS_EN
    // Accumulate flags of delivered results; a clear on a transfer edge keeps only that result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_sticky <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            flags_sticky <= flags_clr ? out_flags_q : (flags_sticky | out_flags_q);
        end else if (flags_clr) begin
            flags_sticky <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Self-checking bench for fp32_mul_round_pack: vector table through a scoreboard,
// plus latency, backpressure, mid-flight reset and (optional) sticky-flag sequences.
module tb_fp32_mul_round_pack;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [31:0] f;
        logic [3:0]  flags;
    } vec_t;

    localparam int NV = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_mul_round_pack_if bus();

`ifdef FP32_MUL_STICKY_FLAGS_EN
    logic [3:0] flags_sticky;
    logic       flags_clr;
`endif

    fp32_mul_round_pack dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FP32_MUL_STICKY_FLAGS_EN
        ,
        .flags_sticky (flags_sticky),
        .flags_clr    (flags_clr)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [35:0] cur_exp;
    logic [35:0] exp_q[$];
    logic [35:0] e_pop;
    vec_t        vecs[NV];
    bit          bp_watch = 0;
    int          bp_first = 0;
    int          bp_last  = 0;
    int          bp_cnt   = 0;
    bit          saw_in_ready_low = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_f;
    logic [3:0]  prev_flags;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [47:0] m,
                                input logic n, input logic i, input logic z,
                                input logic [31:0] f, input logic [3:0] fl);
        vec_t v;
        v.sign = s; v.exp = e; v.mant = m; v.nan = n; v.inf = i; v.zero = z;
        v.f = f; v.flags = fl;
        return v;
    endfunction

    // Scoreboard: pop/compare on output transfer, push on input accept.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_f", 36'(bus.out_f), 36'(prev_f));
                chk("stall_hold_flags", 36'(bus.out_flags), 36'(prev_flags));
                chk("stall_hold_valid", 36'(bus.out_valid), 36'(1));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_f     = bus.out_f;
            prev_flags = bus.out_flags;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got 0x%0h want none", bus.out_f);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("result_f", 36'(bus.out_f), 36'(e_pop[35:4]));
                    chk("result_flags", 36'(bus.out_flags), 36'(e_pop[3:0]));
                end
                if (bp_watch) begin
                    if (bp_cnt == 0) bp_first = cyc;
                    bp_last = cyc;
                    bp_cnt++;
                end
            end
            if (bus.in_valid && !bus.in_ready) saw_in_ready_low = 1;
            if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one input and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic send(input vec_t v);
        int n  = 0;
        bit ok = 0;
        bus.in_sign  = v.sign;
        bus.in_exp   = v.exp;
        bus.in_mant  = v.mant;
        bus.in_nan   = v.nan;
        bus.in_inf   = v.inf;
        bus.in_zero  = v.zero;
        cur_exp      = {v.f, v.flags};
        bus.in_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 within 100 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    // Accept edge loads S1, the next edge loads S2 and raises out_valid.
    task automatic lat_seq(input vec_t v);
        send(v);
        @(negedge clk);
        chk("lat_after_accept", 36'(bus.out_valid), 36'(0));
        @(negedge clk);
        chk("lat_second_edge", 36'(bus.out_valid), 36'(1));
    endtask

    initial begin
        vecs[0]  = mk(0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, 32'h3F80_0000, 4'h0);
        vecs[1]  = mk(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 4'h0);
        vecs[2]  = mk(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 32'h3F80_0000, 4'h1);
        vecs[3]  = mk(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 32'h3F80_0002, 4'h1);
        vecs[4]  = mk(0, 10'd300, 48'h4000_0000_0000, 0, 0, 0, 32'h7F80_0000, 4'h5);
        vecs[5]  = mk(1, 10'h3FB, 48'h4000_0000_0000, 0, 0, 0, 32'h8000_0000, 4'h3);
        vecs[6]  = mk(1, 10'd127, 48'h4000_0000_0000, 0, 1, 1, 32'h7FC0_0000, 4'h8);
        vecs[7]  = mk(1, 10'd127, 48'h4000_0000_0000, 1, 0, 1, 32'h7FC0_0000, 4'h0);
        vecs[8]  = mk(1, 10'd127, 48'h4000_0000_0000, 0, 1, 0, 32'hFF80_0000, 4'h0);
        vecs[9]  = mk(1, 10'd127, 48'h4000_0000_0000, 0, 0, 1, 32'h8000_0000, 4'h0);
        vecs[10] = mk(0, 10'd127, 48'h7FFF_FFFF_FFFF, 0, 0, 0, 32'h4000_0000, 4'h1);
        vecs[11] = mk(0, 10'd254, 48'h4000_0000_0000, 0, 0, 0, 32'h7F00_0000, 4'h0);
        vecs[12] = mk(0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'h7F80_0000, 4'h5);
        vecs[13] = mk(0, 10'd254, 48'h7FFF_FFFF_FFFF, 0, 0, 0, 32'h7F80_0000, 4'h5);
        vecs[14] = mk(0, 10'd1,   48'h4000_0000_0000, 0, 0, 0, 32'h0080_0000, 4'h0);
        vecs[15] = mk(0, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h0000_0000, 4'h3);
        vecs[16] = mk(0, 10'd127, 48'h4000_0050_0000, 0, 0, 0, 32'h3F80_0001, 4'h1);
        vecs[17] = mk(0, 10'd127, 48'h8000_0180_0000, 0, 0, 0, 32'h4000_0002, 4'h1);
        vecs[18] = mk(1, 10'd0,   48'h8000_0000_0000, 0, 0, 0, 32'h8080_0000, 4'h0);
        vecs[19] = mk(0, 10'h3FF, 48'h8000_0000_0000, 0, 0, 0, 32'h0000_0000, 4'h3);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_nan    = 1'b0;
        bus.in_inf    = 1'b0;
        bus.in_zero   = 1'b0;
        bus.out_ready = 1'b1;
        cur_exp       = '0;
`ifdef FP32_MUL_STICKY_FLAGS_EN
        flags_clr     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 36'(bus.in_ready), 36'(1));
        chk("rst_out_valid", 36'(bus.out_valid), 36'(0));
        chk("rst_out_f", 36'(bus.out_f), 36'(0));
        chk("rst_out_flags", 36'(bus.out_flags), 36'(0));
`ifdef FP32_MUL_STICKY_FLAGS_EN
        chk("rst_sticky", 36'(flags_sticky), 36'(0));
`endif

        sync();
        lat_seq(vecs[0]);
        drain();

        // Whole table, back to back
        sync();
        for (int i = 0; i < NV; i++) send(vecs[i]);
        drain();

        // Backpressure: out_ready low for 3 edges once two results are in flight
        sync();
        saw_in_ready_low = 0;
        bp_cnt = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(vecs[i + 1]);
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
                bp_watch = 1;
            end
        join
        drain();
        bp_watch = 0;
        chk("bp_in_ready_dropped", 36'(saw_in_ready_low), 36'(1));
        chk("bp_count", 36'(bp_cnt), 36'(5));
        chk("bp_no_gap", 36'(bp_last - bp_first + 1), 36'(5));

        // Reset with two results in flight
        sync();
        send(vecs[1]);
        send(vecs[4]);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 36'(bus.out_valid), 36'(0));
        chk("midrst_out_f", 36'(bus.out_f), 36'(0));
        chk("midrst_out_flags", 36'(bus.out_flags), 36'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 36'(bus.in_ready), 36'(1));
        chk("midrst_idle_valid", 36'(bus.out_valid), 36'(0));
`ifdef FP32_MUL_STICKY_FLAGS_EN
        chk("midrst_sticky", 36'(flags_sticky), 36'(0));
`endif
        sync();
        lat_seq(vecs[2]);
        drain();

`ifdef FP32_MUL_STICKY_FLAGS_EN
        // Sticky accumulation, idle clear, and clear coincident with a transfer
        sync();
        flags_clr = 1'b1;
        sync();
        flags_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr_idle", 36'(flags_sticky), 36'(0));
        sync();
        send(vecs[4]);
        send(vecs[0]);
        drain();
        chk("sticky_accum", 36'(flags_sticky), 36'(4'h5));
        sync();
        send(vecs[5]);
        @(posedge clk);
        #1 flags_clr = 1'b1;
        @(posedge clk);
        #1 flags_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr_with_xfer", 36'(flags_sticky), 36'(4'h3));
        drain();
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
